// File: rtl/t05_huffman_decoder.sv
// ---------------------------------------------------------------------------
// t05_huffman_decoder
//
// Serial Huffman decoder. Starting at the root element of the htree, it
// fetches one tree element, consumes one compressed bit to choose the left
// or right child, and either descends into a sum node or emits a leaf
// character. After each emitted character it restarts at the root, and it
// stops once the programmed number of characters has been produced.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   start              one-cycle pulse, honoured only in IDLE or DONE
//   max_index          htree index of the root (latched on start)
//   total_chars        characters to decode (latched on start)
//   htree_req/addr     one-cycle element read request and its index
//   htree_valid        h_element holds the requested element
//   h_element          tree element; [63:55] left child, [54:46] right child
//   bit_in/valid/ready compressed bit stream handshake (0 = left, 1 = right)
//   char_out/valid/ready decoded character handshake
//   bits_used          bits consumed since start
//   chars_done         characters emitted since start
//   done, error        decode finished / decode aborted (held until start)
// ---------------------------------------------------------------------------
module t05_huffman_decoder #(
  parameter int CNT_W     = 16,
  parameter int MAX_DEPTH = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       max_index,
  input  logic [CNT_W-1:0] total_chars,
  output logic             htree_req,
  output logic [6:0]       htree_addr,
  input  logic             htree_valid,
  input  logic [70:0]      h_element,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [7:0]       char_out,
  output logic             char_valid,
  input  logic             char_ready,
  output logic [CNT_W-1:0] bits_used,
  output logic [CNT_W-1:0] chars_done,
  output logic             done,
  output logic             error
);

  // Wide enough to hold MAX_DEPTH + 1 so the overflow compare cannot wrap.
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 2);
  localparam logic [8:0] NULL_CHILD = 9'b110000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ELEM,
    S_WAIT_BIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [6:0]         r_root;
  logic [6:0]         r_cur_index;
  logic [DEPTH_W-1:0] r_depth;
  logic [8:0]         r_left;
  logic [8:0]         r_right;
  logic [CNT_W-1:0]   r_remaining;

  logic               r_htree_req;
  logic [6:0]         r_htree_addr;
  logic [7:0]         r_char_out;
  logic               r_char_valid;
  logic [CNT_W-1:0]   r_bits_used;
  logic [CNT_W-1:0]   r_chars_done;
  logic               r_done;
  logic               r_error;

  logic [8:0]         w_child;
  logic [DEPTH_W-1:0] w_depth_next;
  logic               w_unused_elem;

  assign w_child      = bit_in ? r_right : r_left;
  assign w_depth_next = r_depth + DEPTH_W'(1);
  // Only the two child fields of an element are meaningful to the decoder.
  assign w_unused_elem = ^{h_element[70:64], h_element[45:0]};

  // bit_ready is decoded straight from the state so a bit can be taken in the
  // first WAIT_BIT cycle; registering it would cost a cycle per tree level.
  assign bit_ready  = (r_state == S_WAIT_BIT);

  assign htree_req  = r_htree_req;
  assign htree_addr = r_htree_addr;
  assign char_out   = r_char_out;
  assign char_valid = r_char_valid;
  assign bits_used  = r_bits_used;
  assign chars_done = r_chars_done;
  assign done       = r_done;
  assign error      = r_error;

  // NOTE: every register here is assigned with <= so all updates in a cycle
  // see pre-edge values; the reset branch covers every register so no
  // output can come out of reset undefined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_root       <= '0;
      r_cur_index  <= '0;
      r_depth      <= '0;
      r_left       <= '0;
      r_right      <= '0;
      r_remaining  <= '0;
      r_htree_req  <= 1'b0;
      r_htree_addr <= '0;
      r_char_out   <= '0;
      r_char_valid <= 1'b0;
      r_bits_used  <= '0;
      r_chars_done <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_root       <= max_index;
            r_cur_index  <= max_index;
            r_remaining  <= total_chars;
            r_bits_used  <= '0;
            r_chars_done <= '0;
            r_depth      <= '0;
            r_error      <= 1'b0;
            if (total_chars == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_done       <= 1'b0;
              r_htree_req  <= 1'b1;
              r_htree_addr <= max_index;
              r_state      <= S_FETCH;
            end
          end
        end

        // The request was raised on entry; drop it after exactly one cycle.
        S_FETCH: begin
          r_htree_req <= 1'b0;
          r_state     <= S_WAIT_ELEM;
        end

        S_WAIT_ELEM: begin
          if (htree_valid) begin
            r_left  <= h_element[63:55];
            r_right <= h_element[54:46];
            r_state <= S_WAIT_BIT;
          end
        end

        S_WAIT_BIT: begin
          if (bit_valid) begin
            r_bits_used <= r_bits_used + CNT_W'(1);
            r_depth     <= w_depth_next;
            // Null shares bit8=1 with sum nodes, so it must be tested first.
            if (w_child == NULL_CHILD) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (!w_child[8]) begin
              r_char_out   <= w_child[7:0];
              r_char_valid <= 1'b1;
              r_state      <= S_EMIT;
            end else if (w_depth_next > DEPTH_W'(MAX_DEPTH)) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cur_index  <= w_child[6:0];
              r_htree_req  <= 1'b1;
              r_htree_addr <= w_child[6:0];
              r_state      <= S_FETCH;
            end
          end
        end

        S_EMIT: begin
          if (char_ready) begin
            r_char_valid <= 1'b0;
            r_chars_done <= r_chars_done + CNT_W'(1);
            r_remaining  <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cur_index  <= r_root;
              r_depth      <= '0;
              r_htree_req  <= 1'b1;
              r_htree_addr <= r_root;
              r_state      <= S_FETCH;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_huffman_decoder.sv
// ---------------------------------------------------------------------------
// tb_t05_huffman_decoder
//
// Drives the decoder with a small htree memory model and a queued bit
// source; expected characters are queued as stimulus is set up and popped
// when the decoder hands a character out.
// ---------------------------------------------------------------------------
module tb_t05_huffman_decoder;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [6:0]       max_index;
  logic [CNT_W-1:0] total_chars;
  logic             htree_req;
  logic [6:0]       htree_addr;
  logic             htree_valid;
  logic [70:0]      h_element;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [7:0]       char_out;
  logic             char_valid;
  logic             char_ready;
  logic [CNT_W-1:0] bits_used;
  logic [CNT_W-1:0] chars_done;
  logic             done;
  logic             error;

  t05_huffman_decoder #(.CNT_W(CNT_W), .MAX_DEPTH(127)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .max_index  (max_index),
    .total_chars(total_chars),
    .htree_req  (htree_req),
    .htree_addr (htree_addr),
    .htree_valid(htree_valid),
    .h_element  (h_element),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .bits_used  (bits_used),
    .chars_done (chars_done),
    .done       (done),
    .error      (error)
  );

  int checks = 0;
  int errors = 0;

  logic [70:0] mem [0:127];
  int          mem_delay = 0;
  int          mem_cnt   = 0;
  logic [6:0]  mem_addr  = '0;

  logic        bq [$];
  logic [7:0]  sb [$];
  bit          gap_mode = 0;
  bit          gate     = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [70:0] elem(input logic [8:0] l, input logic [8:0] r);
    logic [70:0] e;
    e        = '0;
    e[63:55] = l;
    e[54:46] = r;
    return e;
  endfunction

  // htree memory: answers a request mem_delay cycles after the zero-wait slot.
  initial begin
    htree_valid = 1'b0;
    h_element   = '0;
    forever begin
      @(posedge clk); #1;
      htree_valid = 1'b0;
      if (!rst) mem_cnt = 0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          htree_valid = 1'b1;
          h_element   = mem[mem_addr];
        end
      end
      if (htree_req) begin
        mem_addr = htree_addr;
        mem_cnt  = mem_delay + 1;
      end
    end
  end

  // Bit source: the head of bq is presented until it is accepted.
  initial begin
    bit fire;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    forever begin
      @(negedge clk);
      fire = bit_valid && bit_ready && rst;
      @(posedge clk); #1;
      if (fire && bq.size() > 0) void'(bq.pop_front());
      gate      = gap_mode ? ~gate : 1'b1;
      bit_valid = gate && (bq.size() > 0);
      bit_in    = (bq.size() > 0) ? bq[0] : 1'b0;
    end
  end

  // Character sink: compares each accepted character against the scoreboard.
  initial begin
    logic [7:0] exp_c;
    forever begin
      @(negedge clk);
      if (rst && char_valid && char_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL char_unexpected got %h expected none", char_out);
        end else begin
          exp_c = sb.pop_front();
          if (char_out !== exp_c) begin
            errors++;
            $display("FAIL char_out got %h expected %h", char_out, exp_c);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_tree_a();
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[2] = elem(9'h101, 9'h043);
    mem[1] = elem(9'h041, 9'h042);
  endtask

  task automatic push_abc();
    bq.push_back(1'b0); bq.push_back(1'b0);
    bq.push_back(1'b0); bq.push_back(1'b1);
    bq.push_back(1'b1);
    sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h43);
  endtask

  task automatic do_start(input logic [6:0] root, input logic [CNT_W-1:0] total);
    @(posedge clk); #1;
    max_index   = root;
    total_chars = total;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout done got %b expected 1", name, done);
    end
  endtask

  task automatic wait_char_valid(input string name);
    int n = 0;
    while (!char_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!char_valid) begin
      errors++;
      $display("FAIL %s_char_timeout char_valid got %b expected 1", name, char_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; max_index = '0; total_chars = '0; char_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({htree_req, htree_addr, bit_ready, char_out, char_valid, bits_used,
         chars_done, done, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b addr=%h br=%b c=%h cv=%b bu=%0d cd=%0d d=%b e=%b expected all 0",
               htree_req, htree_addr, bit_ready, char_out, char_valid, bits_used,
               chars_done, done, error);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic(input string name);
    load_tree_a();
    push_abc();
    do_start(7'd2, 16'd3);
    wait_done(name);
    checks++;
    if (bits_used !== 16'd5 || chars_done !== 16'd3 || error !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_end bu=%0d cd=%0d err=%b pend=%0d expected bu=5 cd=3 err=0 pend=0",
               name, bits_used, chars_done, error, sb.size());
    end
  endtask

  task automatic test_stall();
    logic [CNT_W-1:0] bu;
    load_tree_a();
    char_ready = 1'b0;
    push_abc();
    do_start(7'd2, 16'd3);
    wait_char_valid("stall");
    bu = bits_used;
    checks++;
    if (bu !== 16'd2) begin
      errors++;
      $display("FAIL stall_first_bits got %0d expected 2", bu);
    end
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (char_valid !== 1'b1 || char_out !== 8'h41 || bit_ready !== 1'b0 || bits_used !== bu) begin
        errors++;
        $display("FAIL stall_hold cv=%b c=%h br=%b bu=%0d expected cv=1 c=41 br=0 bu=%0d",
                 char_valid, char_out, bit_ready, bits_used, bu);
      end
    end
    char_ready = 1'b1;
    wait_done("stall");
    checks++;
    if (bits_used !== 16'd5 || chars_done !== 16'd3 || error !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_end bu=%0d cd=%0d err=%b pend=%0d expected bu=5 cd=3 err=0 pend=0",
               bits_used, chars_done, error, sb.size());
    end
  endtask

  task automatic test_gapped();
    gap_mode  = 1;
    mem_delay = 3;
    test_basic("gapped");
    gap_mode  = 0;
    mem_delay = 0;
  endtask

  task automatic test_null();
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[0] = elem(9'h041, 9'h180);
    bq.push_back(1'b0); bq.push_back(1'b1);
    sb.push_back(8'h41);
    do_start(7'd0, 16'd2);
    wait_done("null");
    checks++;
    if (error !== 1'b1 || chars_done !== 16'd1 || bits_used !== 16'd2 || sb.size() != 0) begin
      errors++;
      $display("FAIL null_end err=%b cd=%0d bu=%0d pend=%0d expected err=1 cd=1 bu=2 pend=0",
               error, chars_done, bits_used, sb.size());
    end
  endtask

  task automatic test_zero_and_ignore();
    int n = 0;
    do_start(7'd2, 16'd0);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || chars_done !== 16'd0 || bits_used !== 16'd0) begin
      errors++;
      $display("FAIL zero_start d=%b e=%b cd=%0d bu=%0d expected d=1 e=0 cd=0 bu=0",
               done, error, chars_done, bits_used);
    end
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (htree_req !== 1'b0 || bit_ready !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL zero_idle req=%b br=%b d=%b expected req=0 br=0 d=1",
                 htree_req, bit_ready, done);
      end
    end
    // Start while waiting for a bit must not restart or finish the decode.
    load_tree_a();
    do_start(7'd2, 16'd1);
    while (!bit_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    max_index = 7'd1; total_chars = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || bit_ready !== 1'b1 || htree_req !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start d=%b br=%b req=%b expected d=0 br=1 req=0",
               done, bit_ready, htree_req);
    end
    bq.push_back(1'b1);
    sb.push_back(8'h43);
    wait_done("ignore");
    checks++;
    if (chars_done !== 16'd1 || bits_used !== 16'd1 || error !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL ignore_end cd=%0d bu=%0d err=%b pend=%0d expected cd=1 bu=1 err=0 pend=0",
               chars_done, bits_used, error, sb.size());
    end
  endtask

  task automatic test_reset_emit();
    load_tree_a();
    char_ready = 1'b0;
    push_abc();
    do_start(7'd2, 16'd3);
    wait_char_valid("rst_emit");
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++;
    if (char_valid !== 1'b0 || bits_used !== '0 || chars_done !== '0 ||
        htree_req !== 1'b0 || done !== 1'b0 || bit_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_emit cv=%b bu=%0d cd=%0d req=%b d=%b br=%b expected all 0",
               char_valid, bits_used, chars_done, htree_req, done, bit_ready);
    end
    sb.delete();
    bq.delete();
    @(negedge clk);
    rst        = 1'b1;
    char_ready = 1'b1;
    test_basic("after_rst");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_stall();
    test_gapped();
    test_null();
    test_zero_and_ignore();
    test_reset_emit();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
